cp0_except_ctrl: RTL and testbench
==================================

// Module: cp0_except_ctrl
// PURPOSE
//  WB-stage commit point for ExceptinPipeType/AsynExceptType: picks the highest-priority exception, updates CP0.
//  Drives flush/redirect backward up the pipeline, against the forward flow of the ID_EXE/EXE_MEM/MEM_WB regs.
//  Holds CP0 BadVAddr/Count/Compare/Status/Cause/EPC; serves MFC0 reads and MTC0 writes; handles ERET.
// PARAMETERS
//  EXC_VECTOR   32'hBFC0_0380  redirect target for every exception
//  COUNT_DIV    2              Count increments once per COUNT_DIV cycles
// PORTS
//  clk             in   1   core clock
//  rst             in   1   synchronous, active-high reset
//  WB_Valid        in   1   instruction in WB is valid (not a bubble)
//  WB_ExceptType   in   6   ExceptinPipeType of WB instruction
//  WB_IsStore      in   1   MEM address error came from a store (AdES), else load (AdEL)
//  WB_InDelaySlot  in   1   WB instruction sits in a branch delay slot
//  WB_PC           in   32  byte PC of WB instruction
//  WB_BadVAddr     in   32  faulting data address (used when WrongAddressinMEM)
//  WB_Eret         in   1   WB instruction is ERET
//  WB_CP0Wr        in   1   RegsWrType.CP0Wr of WB instruction (MTC0)
//  WB_CP0Addr      in   5   CP0 rd for MTC0
//  WB_CP0WData     in   32  MTC0 data (WB_OutB)
//  ExtInt          in   6   hardware interrupt lines, level-sensitive
//  CP0_RAddr       in   5   MFC0 read address (EXE stage)
//  CP0_RData       out  32  MFC0 read data, combinational; 0 for unimplemented addresses
//  Except_Kill     out  1   combinational: WB instruction must not write RF/HILO this cycle
//  Flush_All       out  1   registered 1-cycle pulse: clear IF/ID, ID/EXE, EXE/MEM, MEM/WB
//  Redirect_Valid  out  1   registered 1-cycle pulse, aligned with Flush_All
//  Redirect_PC     out  32  next fetch PC while Redirect_Valid
//  CP0_Status_IE   out  1   Status.IE, for debug/diff-test
// BEHAVIOUR
//  Reset: Status=32'h0040_0000 (BEV=1, IE=0, EXL=0); Cause/EPC/BadVAddr/Count/Compare=0; all outputs 0; FSM=RUN.
//  Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
//  Cause.IP[7:2] <- {TimerInt|ExtInt[5], ExtInt[4:0]} every cycle; IP[1:0] written only by MTC0.
//  Take condition (RUN, WB_Valid): interrupt pending or any ExceptType bit set.
//  Priority/ExcCode: Interrupt 0 > WrongAddressinIF 4 (BadVAddr=WB_PC) > ReservedInstruction 10
//    > Overflow 12 > Syscall 8 > Break 9 > WrongAddressinMEM 4/5 (BadVAddr=WB_BadVAddr).
//  Take, cycle t: Except_Kill=1; MTC0/ERET of that instruction suppressed.
//  Edge t+1: Cause.ExcCode set; EXL=1; if EXL was 0: EPC=WB_PC-4 & BD=1 when InDelaySlot, else WB_PC & BD=0.
//    If EXL already 1: EPC/BD unchanged. Cycle t+1: Flush_All=Redirect_Valid=1, Redirect_PC=EXC_VECTOR.
//  ERET (RUN, WB_Valid, no take): EXL<=0; next cycle redirect to EPC (value before any same-cycle MTC0).
//  FSM: RUN -> FLUSH on take or ERET; FLUSH -> RUN unconditionally. In FLUSH, WB inputs ignored (bubble).
//  MTC0 (RUN, WB_Valid, no take): writable fields only: Status IM[15:8],EXL[1],IE[0]; Cause IP[9:8];
//    EPC all; Count all; Compare all (also clears TimerInt). BadVAddr read-only.
//  Count: +1 every COUNT_DIV cycles, wraps 32'hFFFF_FFFF->0; MTC0 Count wins over increment same cycle.
//  TimerInt: set when Count==Compare (after increment), sticky until MTC0 Compare; Compare==0 still compares.
//  MFC0 in EXE sees CP0 state before the WB edge; no internal bypass (hazard unit stalls MFC0 after MTC0).
//  rst mid-FLUSH: pulse dropped, FSM=RUN, state returns to reset values.
// STRUCTURE
//  CPU_Defines.svh additions: ExcCodeType enum, CP0 address constants (BADVADDR 8, COUNT 9,
//    COMPARE 11, STATUS 12, CAUSE 13, EPC 14), packed Cp0StatusType/Cp0CauseType structs.
//  Sub-module cp0_timer: Count prescaler, Count/Compare regs, TimerInt flag, MTC0 write ports.
// TESTING
//  Syscall at WB_PC=32'hBFC0_0100, not in delay slot -> Except_Kill t; t+1 flush+redirect 32'hBFC0_0380; EPC=...0100, ExcCode=8, EXL=1.
//  Overflow at PC 32'h8000_0024 in delay slot -> EPC=32'h8000_0020, Cause.BD=1, ExcCode=12.
//  IF AdEL + RI + MEM AdES all set -> ExcCode=4, BadVAddr=WB_PC; EXL=1 then Break -> EPC unchanged.
//  MTC0 Compare=5, Status=32'h0040_8001 -> ~10 cycles later IP7=1, interrupt taken, ExcCode=0; MTC0 Compare clears IP7.
//  ERET with EPC=32'h8000_1000 while MTC0 EPC same cycle impossible; ERET -> redirect 32'h8000_1000, EXL=0.
//  Exception on MTC0 Status instruction -> Status unchanged except EXL; rst during FLUSH -> no pulse next cycle.

Source files
------------

// File: rtl/cp0_except_ctrl_pkg.sv
// Shared types and constants for the CP0 exception controller.
//  - CP0 register addresses served by MFC0/MTC0
//  - ExcCode values written into Cause.ExcCode
//  - Bit layout of the 6-bit ExceptinPipeType vector carried down the pipe
//  - Packed Status and Cause register layouts plus their reset/write masks
package cp0_except_ctrl_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // MSB first: WB_ExceptType[5] is the fetch address error, [0] the data address error.
    typedef struct packed {
        logic if_addr_err;
        logic reserved_inst;
        logic overflow;
        logic syscall;
        logic brk;
        logic mem_addr_err;
    } except_pipe_t;

    typedef struct packed {
        logic [8:0] zero_hi;    // 31:23
        logic       bev;        // 22
        logic [5:0] zero_mid;   // 21:16
        logic [7:0] im;         // 15:8
        logic [5:0] zero_lo;    // 7:2
        logic       exl;        // 1
        logic       ie;         // 0
    } cp0_status_t;

    typedef struct packed {
        logic        bd;        // 31
        logic [14:0] zero_hi;   // 30:16
        logic [7:0]  ip;        // 15:8
        logic        zero_mid;  // 7
        logic [4:0]  exc_code;  // 6:2
        logic [1:0]  zero_lo;   // 1:0
    } cp0_cause_t;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    // Software may only change IM[7:0], EXL and IE.
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

endpackage

// File: rtl/cp0_except_ctrl_timer.sv
// CP0 Count/Compare timer.
//  Count advances once every COUNT_DIV cycles; an MTC0 to Count replaces the
//  increment in that cycle. timer_int latches when an increment lands Count on
//  Compare (including a wrap to 0 with Compare==0) and stays set until Compare
//  is rewritten.
// Ports: clk/rst (sync, active-high), count_we/compare_we + wdata (MTC0 write
//  ports), count/compare (register values), timer_int (sticky timer request).
module cp0_except_ctrl_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_r;
    logic [31:0]   count_r;
    logic [31:0]   compare_r;
    logic          timer_int_r;
    logic          tick_s;

    assign tick_s    = (presc_r == PRESC_LAST);
    assign count     = count_r;
    assign compare   = compare_r;
    assign timer_int = timer_int_r;

    // Free-running prescaler that produces one tick per COUNT_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Count register: software write has priority over the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (count_we) begin
            count_r <= wdata;
        end else if (tick_s) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Compare register.
    always_ff @(posedge clk) begin
        if (rst) begin
            compare_r <= 32'd0;
        end else if (compare_we) begin
            compare_r <= wdata;
        end else begin
            compare_r <= compare_r;
        end
    end

    // Sticky timer request: only an increment reaching Compare sets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_int_r <= 1'b0;
        end else if (compare_we) begin
            timer_int_r <= 1'b0;
        end else if (tick_s && !count_we && ((count_r + 32'd1) == compare_r)) begin
            timer_int_r <= 1'b1;
        end else begin
            timer_int_r <= timer_int_r;
        end
    end

endmodule

// File: rtl/cp0_except_ctrl.sv
// WB-stage exception commit point and CP0 register file.
//  Selects the highest-priority exception (interrupt first) for the WB
//  instruction, kills its write-back, updates Status/Cause/EPC/BadVAddr and,
//  one cycle later, pulses Flush_All/Redirect_Valid towards the front of the
//  pipe with Redirect_PC = EXC_VECTOR (exception) or EPC (ERET).
// Ports: WB_* describe the instruction in WB; ExtInt are level interrupts;
//  CP0_RAddr/CP0_RData form the combinational MFC0 read port; Except_Kill is
//  combinational; Flush_All/Redirect_Valid/Redirect_PC are registered;
//  CP0_Status_IE mirrors Status.IE.
module cp0_except_ctrl
    import cp0_except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_Valid,
    input  logic [5:0]  WB_ExceptType,
    input  logic        WB_IsStore,
    input  logic        WB_InDelaySlot,
    input  logic [31:0] WB_PC,
    input  logic [31:0] WB_BadVAddr,
    input  logic        WB_Eret,
    input  logic        WB_CP0Wr,
    input  logic [4:0]  WB_CP0Addr,
    input  logic [31:0] WB_CP0WData,
    input  logic [5:0]  ExtInt,
    input  logic [4:0]  CP0_RAddr,
    output logic [31:0] CP0_RData,
    output logic        Except_Kill,
    output logic        Flush_All,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC,
    output logic        CP0_Status_IE
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]   state_r;
    cp0_status_t  status_r;
    cp0_cause_t   cause_r;
    logic [31:0]  epc_r;
    logic [31:0]  badvaddr_r;
    logic         flush_r;
    logic         redirect_valid_r;
    logic [31:0]  redirect_pc_r;

    logic [31:0]  count_s;
    logic [31:0]  compare_s;
    logic         timer_int_s;

    except_pipe_t exc_s;
    logic         wb_live_s;
    logic         int_pending_s;
    logic         take_s;
    logic         eret_s;
    logic         mtc0_s;
    exc_code_e    exc_code_s;
    logic         set_badvaddr_s;
    logic [31:0]  badvaddr_new_s;
    logic [5:0]   hw_ip_s;

    assign exc_s         = except_pipe_t'(WB_ExceptType);
    // In FLUSH the WB stage holds a bubble regardless of what its inputs say.
    assign wb_live_s     = !rst && (state_r == ST_RUN) && WB_Valid;
    assign int_pending_s = status_r.ie && !status_r.exl && (|(cause_r.ip & status_r.im));
    assign take_s        = wb_live_s && (int_pending_s || (|WB_ExceptType));
    assign eret_s        = wb_live_s && !take_s && WB_Eret;
    assign mtc0_s        = wb_live_s && !take_s && WB_CP0Wr;
    // The timer shares IP7 with ExtInt[5].
    assign hw_ip_s       = {timer_int_s | ExtInt[5], ExtInt[4:0]};

    assign Except_Kill    = take_s;
    assign Flush_All      = flush_r;
    assign Redirect_Valid = redirect_valid_r;
    assign Redirect_PC    = redirect_pc_r;
    assign CP0_Status_IE  = status_r.ie;

    cp0_except_ctrl_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0_s && (WB_CP0Addr == CP0_COUNT)),
        .compare_we (mtc0_s && (WB_CP0Addr == CP0_COMPARE)),
        .wdata      (WB_CP0WData),
        .count      (count_s),
        .compare    (compare_s),
        .timer_int  (timer_int_s)
    );

    // Priority encoder: ExcCode and optional BadVAddr capture for the winner.
    always_comb begin
        exc_code_s     = EXC_INT;
        set_badvaddr_s = 1'b0;
        badvaddr_new_s = WB_PC;
        if (int_pending_s) begin
            exc_code_s = EXC_INT;
        end else if (exc_s.if_addr_err) begin
            exc_code_s     = EXC_ADEL;
            set_badvaddr_s = 1'b1;
            badvaddr_new_s = WB_PC;
        end else if (exc_s.reserved_inst) begin
            exc_code_s = EXC_RI;
        end else if (exc_s.overflow) begin
            exc_code_s = EXC_OV;
        end else if (exc_s.syscall) begin
            exc_code_s = EXC_SYS;
        end else if (exc_s.brk) begin
            exc_code_s = EXC_BP;
        end else if (exc_s.mem_addr_err) begin
            exc_code_s     = WB_IsStore ? EXC_ADES : EXC_ADEL;
            set_badvaddr_s = 1'b1;
            badvaddr_new_s = WB_BadVAddr;
        end else begin
            exc_code_s = EXC_INT;
        end
    end

    // MFC0 read mux; unimplemented addresses read as zero.
    always_comb begin
        case (CP0_RAddr)
            CP0_BADVADDR: CP0_RData = badvaddr_r;
            CP0_COUNT:    CP0_RData = count_s;
            CP0_COMPARE:  CP0_RData = compare_s;
            CP0_STATUS:   CP0_RData = status_r;
            CP0_CAUSE:    CP0_RData = cause_r;
            CP0_EPC:      CP0_RData = epc_r;
            default:      CP0_RData = 32'd0;
        endcase
    end

    // CP0 architectural state: exception entry, ERET, then MTC0 in that priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_r   <= cp0_status_t'(STATUS_RESET);
            cause_r    <= '0;
            epc_r      <= 32'd0;
            badvaddr_r <= 32'd0;
        end else begin
            cause_r.ip[7:2] <= hw_ip_s;
            if (take_s) begin
                cause_r.exc_code <= exc_code_s;
                status_r.exl     <= 1'b1;
                // A nested exception keeps the original return point.
                if (!status_r.exl) begin
                    epc_r      <= WB_InDelaySlot ? (WB_PC - 32'd4) : WB_PC;
                    cause_r.bd <= WB_InDelaySlot;
                end
                if (set_badvaddr_s) begin
                    badvaddr_r <= badvaddr_new_s;
                end
            end else if (eret_s) begin
                status_r.exl <= 1'b0;
            end else if (mtc0_s) begin
                case (WB_CP0Addr)
                    CP0_STATUS: status_r <= cp0_status_t'((status_r & ~STATUS_WMASK)
                                                          | (WB_CP0WData & STATUS_WMASK));
                    CP0_CAUSE:  cause_r.ip[1:0] <= WB_CP0WData[9:8];
                    CP0_EPC:    epc_r <= WB_CP0WData;
                    default:    epc_r <= epc_r;
                endcase
            end else begin
                epc_r <= epc_r;
            end
        end
    end

    // RUN/FLUSH sequencer producing the one-cycle flush and redirect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_RUN;
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (take_s || eret_s) begin
                        state_r          <= ST_FLUSH;
                        flush_r          <= 1'b1;
                        redirect_valid_r <= 1'b1;
                        // epc_r here is the pre-edge value.
                        redirect_pc_r    <= take_s ? EXC_VECTOR : epc_r;
                    end else begin
                        state_r          <= ST_RUN;
                        flush_r          <= 1'b0;
                        redirect_valid_r <= 1'b0;
                        redirect_pc_r    <= 32'd0;
                    end
                end
                ST_FLUSH: begin
                    state_r          <= ST_RUN;
                    flush_r          <= 1'b0;
                    redirect_valid_r <= 1'b0;
                    redirect_pc_r    <= 32'd0;
                end
                default: begin
                    state_r          <= ST_RUN;
                    flush_r          <= 1'b0;
                    redirect_valid_r <= 1'b0;
                    redirect_pc_r    <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Self-checking bench for cp0_except_ctrl: directed scenarios against fixed
// expected values plus a randomized run against a cycle-level reference model
// of the CP0 rules.
module tb_cp0_except_ctrl;
    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_Valid, WB_IsStore, WB_InDelaySlot, WB_Eret, WB_CP0Wr;
    logic [5:0]  WB_ExceptType, ExtInt;
    logic [31:0] WB_PC, WB_BadVAddr, WB_CP0WData;
    logic [4:0]  WB_CP0Addr, CP0_RAddr;
    logic [31:0] CP0_RData, Redirect_PC;
    logic        Except_Kill, Flush_All, Redirect_Valid, CP0_Status_IE;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] m_status, m_epc, m_badv, m_count, m_compare, m_rpc;
    logic [7:0]  m_ip;
    logic [4:0]  m_exc;
    logic        m_bd, m_timer, m_fl, m_in_flush;
    int          m_edges;

    cp0_except_ctrl #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .WB_Valid(WB_Valid), .WB_ExceptType(WB_ExceptType),
        .WB_IsStore(WB_IsStore), .WB_InDelaySlot(WB_InDelaySlot), .WB_PC(WB_PC),
        .WB_BadVAddr(WB_BadVAddr), .WB_Eret(WB_Eret), .WB_CP0Wr(WB_CP0Wr),
        .WB_CP0Addr(WB_CP0Addr), .WB_CP0WData(WB_CP0WData), .ExtInt(ExtInt),
        .CP0_RAddr(CP0_RAddr), .CP0_RData(CP0_RData), .Except_Kill(Except_Kill),
        .Flush_All(Flush_All), .Redirect_Valid(Redirect_Valid),
        .Redirect_PC(Redirect_PC), .CP0_Status_IE(CP0_Status_IE)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_status = 32'h0040_0000; m_epc = 32'd0; m_badv = 32'd0; m_count = 32'd0;
        m_compare = 32'd0; m_rpc = 32'd0; m_ip = 8'd0; m_exc = 5'd0; m_bd = 1'b0;
        m_timer = 1'b0; m_fl = 1'b0; m_in_flush = 1'b0; m_edges = 0;
    endtask

    function automatic logic m_pending();
        return m_status[0] && !m_status[1] && ((m_ip & m_status[15:8]) != 8'd0);
    endfunction

    function automatic logic m_take();
        return !rst && !m_in_flush && WB_Valid && (m_pending() || WB_ExceptType != 6'd0);
    endfunction

    // Walk the priority list from highest to lowest.
    function automatic logic [4:0] m_code();
        int          bits[5] = '{5, 4, 3, 2, 1};
        logic [4:0]  codes[5] = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9};
        if (m_pending()) return 5'd0;
        for (int i = 0; i < 5; i++) if (WB_ExceptType[bits[i]]) return codes[i];
        return WB_IsStore ? 5'd5 : 5'd4;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return {m_bd, 15'd0, m_ip, 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs held across it.
    task automatic model_edge();
        logic tk, er, wr, tick, pend;
        logic [31:0] old_epc;
        if (rst) begin model_reset(); return; end
        pend = m_pending();
        tk = m_take();
        er = !tk && !m_in_flush && WB_Valid && WB_Eret;
        wr = !tk && !m_in_flush && WB_Valid && WB_CP0Wr;
        old_epc = m_epc;
        tick = (m_edges % DIV) == (DIV - 1);
        m_edges++;
        m_ip[7:2] = {m_timer | ExtInt[5], ExtInt[4:0]};
        if (wr && WB_CP0Addr == 5'd13) m_ip[1:0] = WB_CP0WData[9:8];
        if (wr && WB_CP0Addr == 5'd11) begin
            m_compare = WB_CP0WData; m_timer = 1'b0;
            if (tick) m_count = m_count + 32'd1;
        end else if (wr && WB_CP0Addr == 5'd9) begin
            m_count = WB_CP0WData;
        end else if (tick) begin
            m_count = m_count + 32'd1;
            if (m_count == m_compare) m_timer = 1'b1;
        end
        if (tk) begin
            m_exc = m_code();
            if (!m_status[1]) begin
                m_epc = WB_InDelaySlot ? WB_PC - 32'd4 : WB_PC;
                m_bd  = WB_InDelaySlot;
            end
            m_status[1] = 1'b1;
            if (!pend && WB_ExceptType[5]) m_badv = WB_PC;
            else if (!pend && WB_ExceptType[4:1] == 4'd0 && WB_ExceptType[0]) m_badv = WB_BadVAddr;
        end else if (er) begin
            m_status[1] = 1'b0;
        end else if (wr && WB_CP0Addr == 5'd12) begin
            m_status = (m_status & ~32'h0000_FF03) | (WB_CP0WData & 32'h0000_FF03);
        end else if (wr && WB_CP0Addr == 5'd14) begin
            m_epc = WB_CP0WData;
        end
        m_fl = tk || er;
        m_rpc = tk ? VEC : old_epc;
        m_in_flush = tk || er;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        WB_Valid = 1'b0; WB_ExceptType = 6'd0; WB_IsStore = 1'b0; WB_InDelaySlot = 1'b0;
        WB_PC = 32'd0; WB_BadVAddr = 32'd0; WB_Eret = 1'b0; WB_CP0Wr = 1'b0;
        WB_CP0Addr = 5'd0; WB_CP0WData = 32'd0; ExtInt = 6'd0; CP0_RAddr = 5'd0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle_inputs(); WB_Valid = 1'b1; WB_CP0Wr = 1'b1; WB_CP0Addr = a; WB_CP0WData = d;
        step();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs(); rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1; WB_Valid = 1'b1; WB_ExceptType = 6'b000100; CP0_RAddr = 5'd12; #1;
        n_cmp++; if (Except_Kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill got %b want 0", Except_Kill); end
        n_cmp++; if (CP0_RData !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_status got %h want 00400000", CP0_RData); end
        step(); rst = 1'b0; idle_inputs(); CP0_RAddr = 5'd13; #1;
        n_cmp++; if ({Flush_All, Redirect_Valid, CP0_Status_IE} !== 3'b000) begin n_fail++; $display("FAIL reset_outs got %b want 000", {Flush_All, Redirect_Valid, CP0_Status_IE}); end
        n_cmp++; if (CP0_RData !== 32'd0) begin n_fail++; $display("FAIL reset_cause got %h want 0", CP0_RData); end
    endtask

    task automatic test_syscall();
        do_reset();
        WB_Valid = 1'b1; WB_ExceptType = 6'b000100; WB_PC = 32'hBFC0_0100; #1;
        n_cmp++; if (Except_Kill !== 1'b1) begin n_fail++; $display("FAIL sys_kill got %b want 1", Except_Kill); end
        step(); idle_inputs();
        n_cmp++; if ({Flush_All, Redirect_Valid} !== 2'b11 || Redirect_PC !== 32'hBFC0_0380) begin
            n_fail++; $display("FAIL sys_redirect got %b%b %h want 11 bfc00380", Flush_All, Redirect_Valid, Redirect_PC); end
        CP0_RAddr = 5'd14; #1;
        n_cmp++; if (CP0_RData !== 32'hBFC0_0100) begin n_fail++; $display("FAIL sys_epc got %h want bfc00100", CP0_RData); end
        CP0_RAddr = 5'd13; #1;
        n_cmp++; if (CP0_RData[6:2] !== 5'd8 || CP0_RData[31] !== 1'b0) begin n_fail++; $display("FAIL sys_cause got %h want exc 8 bd 0", CP0_RData); end
        CP0_RAddr = 5'd12; #1;
        n_cmp++; if (CP0_RData !== 32'h0040_0002) begin n_fail++; $display("FAIL sys_status got %h want 00400002", CP0_RData); end
        step();
        n_cmp++; if (Flush_All !== 1'b0) begin n_fail++; $display("FAIL sys_one_pulse got %b want 0", Flush_All); end
    endtask

    task automatic test_overflow_ds();
        do_reset();
        WB_Valid = 1'b1; WB_ExceptType = 6'b001000; WB_PC = 32'h8000_0024; WB_InDelaySlot = 1'b1;
        step(); idle_inputs(); CP0_RAddr = 5'd14; #1;
        n_cmp++; if (CP0_RData !== 32'h8000_0020) begin n_fail++; $display("FAIL ov_epc got %h want 80000020", CP0_RData); end
        CP0_RAddr = 5'd13; #1;
        n_cmp++; if (CP0_RData[31] !== 1'b1 || CP0_RData[6:2] !== 5'd12) begin n_fail++; $display("FAIL ov_cause got %h want bd 1 exc 12", CP0_RData); end
        step();
    endtask

    task automatic test_priority_nested();
        do_reset();
        WB_Valid = 1'b1; WB_ExceptType = 6'b110001; WB_IsStore = 1'b1;
        WB_PC = 32'h8000_0040; WB_BadVAddr = 32'hDEAD_BEE0;
        step(); idle_inputs(); CP0_RAddr = 5'd13; #1;
        n_cmp++; if (CP0_RData[6:2] !== 5'd4) begin n_fail++; $display("FAIL prio_code got %0d want 4", CP0_RData[6:2]); end
        CP0_RAddr = 5'd8; #1;
        n_cmp++; if (CP0_RData !== 32'h8000_0040) begin n_fail++; $display("FAIL prio_badv got %h want 80000040", CP0_RData); end
        step();
        WB_Valid = 1'b1; WB_ExceptType = 6'b000010; WB_PC = 32'h8000_0080; #1;
        n_cmp++; if (Except_Kill !== 1'b1) begin n_fail++; $display("FAIL nest_kill got %b want 1", Except_Kill); end
        step(); idle_inputs(); CP0_RAddr = 5'd14; #1;
        n_cmp++; if (CP0_RData !== 32'h8000_0040) begin n_fail++; $display("FAIL nest_epc got %h want 80000040", CP0_RData); end
        CP0_RAddr = 5'd13; #1;
        n_cmp++; if (CP0_RData[6:2] !== 5'd9) begin n_fail++; $display("FAIL nest_code got %0d want 9", CP0_RData[6:2]); end
        step();
        WB_Valid = 1'b1; WB_ExceptType = 6'b000001; WB_IsStore = 1'b1;
        WB_PC = 32'h8000_00C0; WB_BadVAddr = 32'h1234_5677;
        step(); idle_inputs(); CP0_RAddr = 5'd13; #1;
        n_cmp++; if (CP0_RData[6:2] !== 5'd5) begin n_fail++; $display("FAIL ades_code got %0d want 5", CP0_RData[6:2]); end
        CP0_RAddr = 5'd8; #1;
        n_cmp++; if (CP0_RData !== 32'h1234_5677) begin n_fail++; $display("FAIL ades_badv got %h want 12345677", CP0_RData); end
        step();
    endtask

    task automatic test_timer_int();
        bit found = 1'b0;
        do_reset();
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h0040_8001);
        n_cmp++; if (CP0_Status_IE !== 1'b1) begin n_fail++; $display("FAIL tmr_ie got %b want 1", CP0_Status_IE); end
        for (int i = 0; i < 40 && !found; i++) begin
            CP0_RAddr = 5'd13; #1;
            if (CP0_RData[15]) found = 1'b1;
            else step();
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL tmr_ip7 got 0 want 1 within 40 cycles"); end
        CP0_RAddr = 5'd9; #1;
        n_cmp++; if (CP0_RData !== 32'd5) begin n_fail++; $display("FAIL tmr_count got %0d want 5", CP0_RData); end
        WB_Valid = 1'b1; WB_PC = 32'h8000_0200; #1;
        n_cmp++; if (Except_Kill !== 1'b1) begin n_fail++; $display("FAIL tmr_kill got %b want 1", Except_Kill); end
        step(); idle_inputs(); CP0_RAddr = 5'd13; #1;
        n_cmp++; if (CP0_RData[6:2] !== 5'd0 || Flush_All !== 1'b1) begin n_fail++; $display("FAIL tmr_take got code %0d flush %b want 0 1", CP0_RData[6:2], Flush_All); end
        step();
        mtc0(5'd11, 32'd100);
        step(); CP0_RAddr = 5'd13; #1;
        n_cmp++; if (CP0_RData[15] !== 1'b0) begin n_fail++; $display("FAIL tmr_clear got %b want 0", CP0_RData[15]); end
    endtask

    task automatic test_eret();
        do_reset();
        mtc0(5'd14, 32'h8000_1000);
        mtc0(5'd12, 32'h0000_0002);
        CP0_RAddr = 5'd12; #1;
        n_cmp++; if (CP0_RData !== 32'h0040_0002) begin n_fail++; $display("FAIL eret_pre got %h want 00400002", CP0_RData); end
        WB_Valid = 1'b1; WB_Eret = 1'b1; #1;
        n_cmp++; if (Except_Kill !== 1'b0) begin n_fail++; $display("FAIL eret_kill got %b want 0", Except_Kill); end
        step();
        n_cmp++; if ({Flush_All, Redirect_Valid} !== 2'b11 || Redirect_PC !== 32'h8000_1000) begin
            n_fail++; $display("FAIL eret_redirect got %b%b %h want 11 80001000", Flush_All, Redirect_Valid, Redirect_PC); end
        #1;
        n_cmp++; if (CP0_RData !== 32'h0040_0000) begin n_fail++; $display("FAIL eret_exl got %h want 00400000", CP0_RData); end
        step(); idle_inputs();
        n_cmp++; if (Flush_All !== 1'b0) begin n_fail++; $display("FAIL eret_flush_ignored got %b want 0", Flush_All); end
    endtask

    task automatic test_exc_on_mtc0();
        do_reset();
        WB_Valid = 1'b1; WB_CP0Wr = 1'b1; WB_CP0Addr = 5'd12; WB_CP0WData = 32'h0000_FF01;
        WB_ExceptType = 6'b000100; #1;
        n_cmp++; if (Except_Kill !== 1'b1) begin n_fail++; $display("FAIL mtc0exc_kill got %b want 1", Except_Kill); end
        step(); idle_inputs(); CP0_RAddr = 5'd12; #1;
        n_cmp++; if (CP0_RData !== 32'h0040_0002) begin n_fail++; $display("FAIL mtc0exc_status got %h want 00400002", CP0_RData); end
        step();
    endtask

    task automatic test_rst_flush();
        do_reset();
        WB_Valid = 1'b1; WB_ExceptType = 6'b000100; WB_PC = 32'h8000_0300;
        step(); idle_inputs(); rst = 1'b1;
        step(); rst = 1'b0;
        n_cmp++; if ({Flush_All, Redirect_Valid} !== 2'b00) begin n_fail++; $display("FAIL rst_flush_pulse got %b%b want 00", Flush_All, Redirect_Valid); end
        CP0_RAddr = 5'd14; WB_Valid = 1'b1; WB_ExceptType = 6'b000100; #1;
        n_cmp++; if (Except_Kill !== 1'b1 || CP0_RData !== 32'd0) begin n_fail++; $display("FAIL rst_flush_run got kill %b epc %h want 1 0", Except_Kill, CP0_RData); end
        rst = 1'b1; #1;
        step(); rst = 1'b0; idle_inputs();
        n_cmp++; if (Flush_All !== 1'b0) begin n_fail++; $display("FAIL rst_take_pulse got %b want 0", Flush_All); end
    endtask

    task automatic test_random();
        int addrs[7] = '{8, 9, 11, 12, 13, 14, 3};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            WB_Valid       = ($urandom_range(0, 3) != 0);
            WB_ExceptType  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'd0;
            WB_IsStore     = 1'($urandom);
            WB_InDelaySlot = 1'($urandom);
            WB_PC          = {$urandom} & 32'hFFFF_FFFC;
            WB_BadVAddr    = $urandom;
            WB_Eret        = ($urandom_range(0, 7) == 0);
            WB_CP0Wr       = !WB_Eret && ($urandom_range(0, 2) == 0);
            WB_CP0Addr     = 5'(addrs[$urandom_range(0, 6)]);
            WB_CP0WData    = $urandom;
            if (WB_CP0Addr == 5'd11 && $urandom_range(0, 1) == 0) WB_CP0WData = m_count + 32'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) ExtInt = 6'($urandom);
            CP0_RAddr      = 5'($urandom_range(0, 15));
            #1;
            n_cmp++; if (Except_Kill !== m_take()) begin n_fail++; $display("FAIL rnd_kill[%0d] got %b want %b", i, Except_Kill, m_take()); end
            n_cmp++; if (CP0_RData !== m_read(CP0_RAddr)) begin n_fail++; $display("FAIL rnd_rdata[%0d] addr %0d got %h want %h", i, CP0_RAddr, CP0_RData, m_read(CP0_RAddr)); end
            step();
            n_cmp++; if ({Flush_All, Redirect_Valid, CP0_Status_IE} !== {m_fl, m_fl, m_status[0]}) begin
                n_fail++; $display("FAIL rnd_outs[%0d] got %b want %b", i, {Flush_All, Redirect_Valid, CP0_Status_IE}, {m_fl, m_fl, m_status[0]}); end
            if (m_fl) begin
                n_cmp++; if (Redirect_PC !== m_rpc) begin n_fail++; $display("FAIL rnd_rpc[%0d] got %h want %h", i, Redirect_PC, m_rpc); end
            end
        end
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_syscall();
        test_overflow_ds();
        test_priority_nested();
        test_timer_int();
        test_eret();
        test_exc_on_mtc0();
        test_rst_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
